// File: rtl/pe_network_interface.sv
// Local-port network interface: packs PE payloads into single-flit packets, injects them under
// credit flow control, and buffers ejected flits for the PE. Define NI_LOOPBACK_EN for local loopback.
module pe_network_interface #(
    parameter int TX_DEPTH         = 4,
    parameter int RX_DEPTH         = 4,
    parameter int ROUTER_BUF_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            my_cluster,
    input  logic [1:0]                            my_local,
    input  logic [15:0]                           tx_data,
    input  logic [1:0]                            tx_dst_cluster,
    input  logic [1:0]                            tx_dst_local,
    input  logic                                  tx_valid,
    output logic                                  tx_ready,
    output logic [19:0]                           inject,
    output logic                                  inject_valid,
    input  logic                                  credit_in,
    input  logic [19:0]                           eject,
    input  logic                                  eject_valid,
    output logic [15:0]                           rx_data,
    output logic                                  rx_valid,
    input  logic                                  rx_ready,
    output logic [$clog2(ROUTER_BUF_DEPTH+1)-1:0] credits,
    output logic                                  rx_overflow,
    output logic                                  credit_err,
    output logic [7:0]                            drop_count
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int CW    = $clog2(ROUTER_BUF_DEPTH + 1);

    localparam logic [CW-1:0]    CREDIT_MAX = CW'(ROUTER_BUF_DEPTH);
    localparam logic [CW-1:0]    CREDIT_ONE = CW'(1);
    localparam logic [TX_AW:0]   TX_PTR_ONE = (TX_AW + 1)'(1);
    localparam logic [RX_AW:0]   RX_PTR_ONE = (RX_AW + 1)'(1);

    logic [19:0]    tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr;
    logic [19:0]    tx_head;
    logic           tx_empty, tx_full, tx_push, tx_pop, tx_inject;

    logic [15:0]    rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;
    logic [15:0]    rx_wdata;
    logic           rx_empty, rx_full, rx_push, rx_pop, rx_drop;

    logic           lb_hit, lb_go;
    logic           unused_eject_dst;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;
    assign tx_head  = tx_mem[tx_rd_ptr[TX_AW-1:0]];

`ifdef NI_LOOPBACK_EN
    // Locally addressed heads go straight to RX; router ejection owns the RX write port first.
    assign lb_hit = !tx_empty && (tx_head[19:16] == {my_cluster, my_local});
    assign lb_go  = lb_hit && !eject_valid && !rx_full;
`else
    logic unused_ids;
    assign lb_hit     = 1'b0;
    assign lb_go      = 1'b0;
    assign unused_ids = ^{my_cluster, my_local};
`endif

    assign tx_inject = !tx_empty && !lb_hit && (credits != '0);
    assign tx_pop    = tx_inject || lb_go;

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[TX_AW-1:0]] <= {tx_dst_cluster, tx_dst_local, tx_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inject       <= '0;
            inject_valid <= 1'b0;
        end else begin
            inject_valid <= tx_inject;
            if (tx_inject) inject <= tx_head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits    <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else begin
            unique case ({tx_inject, credit_in})
                2'b10: credits <= credits - CREDIT_ONE;
                2'b01: begin
                    if (credits == CREDIT_MAX) credit_err <= 1'b1;
                    else                       credits    <= credits + CREDIT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_mem[rx_rd_ptr[RX_AW-1:0]];
    assign rx_pop   = rx_valid && rx_ready;

    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign rx_push  = (eject_valid || lb_go) && (!rx_full || rx_pop);
    assign rx_drop  = eject_valid && rx_full && !rx_pop;
    assign rx_wdata = eject_valid ? eject[15:0] : tx_head[15:0];
    assign unused_eject_dst = ^eject[19:16];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_overflow <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            if (rx_drop) begin
                rx_overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/pe_network_interface.md
Name: pe_network_interface

Overview:
- Local-port network interface between a node's router local port (in5/vi5 inject, o5/vo5 eject, co5 credit) and its processing element.
- Packs PE payloads into 20-bit single-flit packets and queues them for injection.
- Injects under credit-based flow control against the router's local input buffer.
- Buffers ejected flits for the PE; the router's local output port has no back-pressure, so every ejected flit must be accepted or counted as dropped.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of two, >=2)
- RX_DEPTH, 4, RX FIFO entries (power of two, >=2)
- ROUTER_BUF_DEPTH, 4, router local input buffer depth; initial and maximum credit count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- my_cluster  in  2  this node's cluster id
- my_local  in  2  this node's local id
- tx_data  in  16  PE payload to send
- tx_dst_cluster  in  2  destination cluster
- tx_dst_local  in  2  destination local id
- tx_valid  in  1  PE offers a payload
- tx_ready  out  1  TX FIFO not full
- inject  out  20  flit to router in5
- inject_valid  out  1  flit valid to router vi5
- credit_in  in  1  credit return from router co5, one pulse per freed slot
- eject  in  20  flit from router o5
- eject_valid  in  1  flit valid from router vo5
- rx_data  out  16  payload at head of RX FIFO
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  PE consumes head
- credits  out  clog2(ROUTER_BUF_DEPTH+1)  current credit count
- rx_overflow  out  1  sticky: an ejected flit was dropped
- credit_err  out  1  sticky: credit_in received while credits at maximum
- drop_count  out  8  dropped ejected flits, saturating

Behaviour:
- Reset (rst low, asynchronous): FIFOs empty, inject=0, inject_valid=0, credits=ROUTER_BUF_DEPTH, rx_overflow=0, credit_err=0, drop_count=0.
- Flit format: [19:18]=dst cluster, [17:16]=dst local, [15:0]=payload.
- TX accept: push on tx_valid && tx_ready. tx_ready = !tx_full, registered status; no combinational path from tx_valid.
- Inject: when TX FIFO is non-empty and credits>0, the head is popped into the inject register and inject_valid=1 for exactly one cycle per flit.
  - Back-to-back injection is allowed while credits remain.
  - Minimum latency: a flit pushed at edge N appears on inject after edge N+1.
  - inject holds its last value while inject_valid=0.
- Credits: decrement by 1 per injected flit, increment by 1 per credit_in pulse.
  - Injection and credit_in in the same cycle leave credits unchanged.
  - credit_in at the maximum with no injection that cycle: credits stay at max and credit_err is set.
  - credits=0: injection stalls; the TX FIFO fills and tx_ready drops at TX_DEPTH entries.
- RX push: on eject_valid, eject[15:0] is written to the RX FIFO.
  - Full with a simultaneous pop (rx_valid && rx_ready): push succeeds and the count is unchanged.
  - Full without a pop: the flit is dropped, rx_overflow is set, and drop_count increments, saturating at 255.
- RX pop: first-word-fall-through. rx_data is the head, rx_valid = !rx_empty, and the head pops on rx_valid && rx_ready.
- Pointer wrap: read/write pointers are clog2(depth)+1 bits; full and empty are decided by the MSB compare.
- Simultaneous push and pop on an empty FIFO: the pushed word becomes visible on the next cycle.
- Sticky flags clear only on reset.
- Reset mid-operation: all in-flight flits are discarded. The router must be reset in the same cycle so that credits stay consistent.

Optional Feature:
- Macro: NI_LOOPBACK_EN.
- Defined: a TX head whose destination equals {my_cluster,my_local} bypasses the router.
  - The flit is popped straight into the RX FIFO, using no credit and producing no inject_valid.
  - eject_valid has priority over loopback for the RX write port; loopback stalls that cycle.
  - Loopback also stalls while RX is full; loopback flits are never dropped.
  - Loopback and router injection never occur in the same cycle, since there is a single TX head.
- Undefined: all flits go to the router regardless of destination, and my_cluster/my_local are unused.

Test Plan:
- Reset then push 3 payloads 0x0001..0x0003 to dst (2,1) -> inject = 0x90001, 0x90002, 0x90003 on consecutive cycles; credits 4->1.
- No credit_in, push 6 payloads -> 4 injected, credits=0, TX holds 2 more; tx_ready stays high (FIFO not full). Pulse credit_in once -> exactly one more injection.
- Inject and credit_in in the same cycle at credits=2 -> credits stays 2. Credit_in at credits=4 -> credit_err=1, credits=4.
- rx_ready=0, eject 5 flits -> rx_valid=1, 4 stored, rx_overflow=1, drop_count=1. Drain -> payloads in order, 5th absent.
- RX full, eject_valid and rx_ready in the same cycle -> no drop, count stays 4, new flit at tail.
- NI_LOOPBACK_EN with my ids (1,3): send to (1,3) -> no inject_valid, credits unchanged, payload appears on rx_data. The same send with eject_valid active -> loopback delayed one cycle. Assert rst mid-stream -> all outputs return to their reset values immediately.
